// File: rtl/cpu_core_hs.sv
`timescale 1ns/1ps
// cpu_core_hs: multicycle CPU core with a req/ack memory handshake.
//
// One FSM sequences FETCH -> DECODE -> EXEC -> [MEM] -> WB. Instruction and
// data memory share a single port, and either may stall for any number of
// cycles by withholding mem_ack. The instruction word is mem_rdata[15:0].
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   mem_req    memory request, held until mem_ack
//   mem_we     1 = write, 0 = read (valid with mem_req)
//   mem_addr   memory address (registered, stable over the req window)
//   mem_wdata  write data (registered, stable over the req window)
//   mem_rdata  read data, sampled in the ack cycle
//   mem_ack    completes the transfer when seen together with mem_req
//   dbg_sel    register index for the debug read port
//   dbg_data   combinational read of register dbg_sel
//   halted     high while the core sits in HALT
module cpu_core_hs #(
  parameter int                DATA_W  = 16,
  parameter int                ADDR_W  = 10,
  parameter logic [ADDR_W-1:0] SP_INIT = ~ADDR_W'(1)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic [3:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_ADD = 4'h1, OP_SUB  = 4'h2, OP_AND = 4'h3,
    OP_OR   = 4'h4, OP_ADDI = 4'h5, OP_LDI = 4'h6, OP_LD  = 4'h7,
    OP_ST   = 4'h8, OP_PUSH = 4'h9, OP_POP = 4'hA, OP_JMP = 4'hB,
    OP_JZ   = 4'hC, OP_JN  = 4'hD, OP_JR   = 4'hE, OP_HALT = 4'hF
  } opcode_t;

  state_t              state, state_next;
  logic [15:0]         ir;
  logic [ADDR_W-1:0]   pc, sp;
  logic [DATA_W-1:0]   regs [16];
  logic [DATA_W-1:0]   opa, opb, res, alu_res;
  logic                flag_z, flag_n;

  opcode_t             op;
  logic [3:0]          rx, ry;
  logic [DATA_W-1:0]   imm;
  logic [ADDR_W-1:0]   tgt;
  logic                xfer;

  assign op  = opcode_t'(ir[15:12]);
  assign rx  = ir[11:8];
  assign ry  = ir[7:4];
  assign imm = {{(DATA_W-8){ir[7]}}, ir[7:0]};
  assign tgt = ADDR_W'(ir[11:0]);

  // mem_req is decoded from the registered state and gated by reset so an
  // open transaction is withdrawn the instant reset asserts.
  assign mem_req  = reset && (state == S_FETCH || state == S_MEM);
  assign xfer     = mem_req && mem_ack;
  assign halted   = (state == S_HALT);
  assign dbg_data = regs[dbg_sel];

  // NOTE: every variable driven in always_comb gets a default before the
  // case statement; a missing branch would otherwise infer a latch.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = opa + opb;
      OP_SUB:  alu_res = opa - opb;
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_ADDI: alu_res = opa + imm;
      OP_LDI:  alu_res = imm;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (xfer) state_next = S_DECODE;
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        if (op == OP_HALT)                           state_next = S_HALT;
        else if (op inside {OP_LD, OP_ST, OP_PUSH, OP_POP}) state_next = S_MEM;
        else                                         state_next = S_WB;
      end
      S_MEM:    if (xfer) state_next = S_WB;
      S_WB:     state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= '0;
      sp        <= SP_INIT;
      ir        <= '0;
      opa       <= '0;
      opb       <= '0;
      res       <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      // NOTE: the register file is built from flops, not a RAM macro, so it
      // can and must be cleared by reset like any other architectural state.
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (xfer) begin
            ir <= mem_rdata[15:0];
            pc <= pc + ADDR_W'(1);
          end
        end
        S_DECODE: begin
          opa <= regs[rx];
          opb <= regs[ry];
        end
        S_EXEC: begin
          res <= alu_res;
          if (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI}) begin
            flag_z <= (alu_res == '0);
            flag_n <= alu_res[DATA_W-1];
          end
          // Memory outputs are loaded here so they are already stable in
          // the first MEM cycle and stay put until ack.
          case (op)
            OP_JMP: pc <= tgt;
            OP_JZ:  if (flag_z) pc <= tgt;
            OP_JN:  if (flag_n) pc <= tgt;
            OP_JR:  pc <= opa[ADDR_W-1:0];
            OP_LD: begin
              mem_addr <= opb[ADDR_W-1:0];
              mem_we   <= 1'b0;
            end
            OP_ST: begin
              mem_addr  <= opb[ADDR_W-1:0];
              mem_we    <= 1'b1;
              mem_wdata <= opa;
            end
            OP_PUSH: begin
              mem_addr  <= sp - ADDR_W'(1);
              mem_we    <= 1'b1;
              mem_wdata <= opa;
            end
            OP_POP: begin
              mem_addr <= sp;
              mem_we   <= 1'b0;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          if (xfer) begin
            res <= mem_rdata;
            // SP commits only once the transfer is done; wrap is natural.
            if (op == OP_PUSH) sp <= sp - ADDR_W'(1);
            if (op == OP_POP)  sp <= sp + ADDR_W'(1);
          end
        end
        S_WB: begin
          if (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LDI, OP_LD, OP_POP})
            regs[rx] <= res;
          // Prepare the next fetch address while still outside the req window.
          mem_we   <= 1'b0;
          mem_addr <= pc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core_hs.sv
`timescale 1ns/1ps
// Directed testbench for cpu_core_hs: a narrow (16/10) and a wide (32/12)
// instance, each with its own handshake memory model and transaction log.
module tb_cpu_core_hs;

  typedef struct {
    int          addr;
    bit          we;
    logic [31:0] wdata;
    int          len;
    bit          stable;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- narrow instance ----------------
  logic        rst0 = 1'b0;
  logic        mem_req0, mem_we0, mem_ack0 = 1'b0, halted0;
  logic [9:0]  mem_addr0;
  logic [15:0] mem_wdata0, mem_rdata0 = '0, dbg_data0;
  logic [3:0]  dbg_sel0 = '0;

  cpu_core_hs u_dut0 (
    .clk(clk), .reset(rst0), .mem_req(mem_req0), .mem_we(mem_we0),
    .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0),
    .mem_ack(mem_ack0), .dbg_sel(dbg_sel0), .dbg_data(dbg_data0),
    .halted(halted0)
  );

  // ---------------- wide instance ----------------
  logic        rst1 = 1'b0;
  logic        mem_req1, mem_we1, mem_ack1 = 1'b0, halted1;
  logic [11:0] mem_addr1;
  logic [31:0] mem_wdata1, mem_rdata1 = '0, dbg_data1;
  logic [3:0]  dbg_sel1 = '0;

  cpu_core_hs #(.DATA_W(32), .ADDR_W(12)) u_dut1 (
    .clk(clk), .reset(rst1), .mem_req(mem_req1), .mem_we(mem_we1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
    .mem_ack(mem_ack1), .dbg_sel(dbg_sel1), .dbg_data(dbg_data1),
    .halted(halted1)
  );

  // ---------------- memory models ----------------
  // Ack is decided on the falling edge and held across the rising edge.
  logic [15:0] mem0 [1024];
  logic [31:0] mem1 [4096];
  txn_t        q0[$], q1[$];
  int          wait0 = 0, wcnt0 = 0, len0 = 0;
  int          wait1 = 0, wcnt1 = 0, len1 = 0;
  bit          hold_wr0 = 1'b0, stab0, stab1;
  logic [9:0]  first0;
  logic [11:0] first1;

  always @(negedge clk) begin
    if (mem_req0 === 1'b1) begin
      if (len0 == 0) begin first0 = mem_addr0; stab0 = 1'b1; end
      else if (mem_addr0 !== first0) stab0 = 1'b0;
      len0++;
      if (wcnt0 >= wait0 && !(hold_wr0 && mem_we0)) begin
        mem_ack0   = 1'b1;
        mem_rdata0 = mem0[mem_addr0];
        if (mem_we0) mem0[mem_addr0] = mem_wdata0;
        q0.push_back('{addr: int'(mem_addr0), we: mem_we0, wdata: 32'(mem_wdata0),
                       len: len0, stable: stab0});
        len0 = 0; wcnt0 = 0;
      end else begin
        mem_ack0 = 1'b0; wcnt0++;
      end
    end else begin
      mem_ack0 = 1'b0; wcnt0 = 0; len0 = 0;
    end
  end

  always @(negedge clk) begin
    if (mem_req1 === 1'b1) begin
      if (len1 == 0) begin first1 = mem_addr1; stab1 = 1'b1; end
      else if (mem_addr1 !== first1) stab1 = 1'b0;
      len1++;
      if (wcnt1 >= wait1) begin
        mem_ack1   = 1'b1;
        mem_rdata1 = mem1[mem_addr1];
        if (mem_we1) mem1[mem_addr1] = mem_wdata1;
        q1.push_back('{addr: int'(mem_addr1), we: mem_we1, wdata: mem_wdata1,
                       len: len1, stable: stab1});
        len1 = 0; wcnt1 = 0;
      end else begin
        mem_ack1 = 1'b0; wcnt1++;
      end
    end else begin
      mem_ack1 = 1'b0; wcnt1 = 0; len1 = 0;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear0();
    for (int i = 0; i < 1024; i++) mem0[i] = '0;
  endtask

  task automatic reset0();
    rst0 = 1'b0;
    q0.delete();
    repeat (2) @(posedge clk);
    #1 rst0 = 1'b1;
  endtask

  task automatic reg0(input string tag, input int r, input logic [31:0] exp);
    dbg_sel0 = 4'(r);
    #1 check(tag, 32'(dbg_data0), exp);
  endtask

  task automatic reg1(input string tag, input int r, input logic [31:0] exp);
    dbg_sel1 = 4'(r);
    #1 check(tag, dbg_data1, exp);
  endtask

  task automatic wait_halt0(input string tag, input int budget);
    int i = 0;
    while (halted0 !== 1'b1 && i < budget) begin @(negedge clk); #1; i++; end
    check(tag, 32'(halted0), 32'd1);
  endtask

  task automatic wait_halt1(input string tag, input int budget);
    int i = 0;
    while (halted1 !== 1'b1 && i < budget) begin @(negedge clk); #1; i++; end
    check(tag, 32'(halted1), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    // Test 1: zero-wait program, exact halt timing.
    clear0();
    mem0[0] = 16'h6105;  // LDI r1,5
    mem0[1] = 16'h62FD;  // LDI r2,-3
    mem0[2] = 16'h1120;  // ADD r1,r2
    mem0[3] = 16'hF000;  // HALT
    wait0 = 0;
    #3;
    check("rst_mem_req",   32'(mem_req0),   32'd0);
    check("rst_mem_we",    32'(mem_we0),    32'd0);
    check("rst_mem_addr",  32'(mem_addr0),  32'd0);
    check("rst_mem_wdata", 32'(mem_wdata0), 32'd0);
    check("rst_halted",    32'(halted0),    32'd0);
    reg0("rst_r1", 1, 32'd0);
    reset0();
    repeat (14) @(posedge clk);
    @(negedge clk); #1;
    check("t1_not_halted_c15", 32'(halted0), 32'd0);
    @(posedge clk); @(negedge clk); #1;
    check("t1_halted_c16", 32'(halted0), 32'd1);
    check("t1_txn_count", 32'(q0.size()), 32'd4);
    check("t1_halt_fetch_addr", 32'(q0[3].addr), 32'd3);
    repeat (5) @(negedge clk);
    #1;
    check("t1_no_req_after_halt", 32'(mem_req0), 32'd0);
    check("t1_txn_count_late", 32'(q0.size()), 32'd4);
    reg0("t1_r1", 1, 32'h0002);
    reg0("t1_r2", 2, 32'hFFFD);
    check("t1_flag_z", 32'(u_dut0.flag_z), 32'd0);
    check("t1_flag_n", 32'(u_dut0.flag_n), 32'd0);

    // Test 2: same program with three wait cycles per transfer.
    wait0 = 3;
    reset0();
    wait_halt0("t2_halt", 200);
    reg0("t2_r1", 1, 32'h0002);
    reg0("t2_r2", 2, 32'hFFFD);
    check("t2_txn_count", 32'(q0.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_fetch%0d_len", i),    32'(q0[i].len),    32'd4);
      check($sformatf("t2_fetch%0d_stable", i), 32'(q0[i].stable), 32'd1);
      check($sformatf("t2_fetch%0d_addr", i),   32'(q0[i].addr),   32'(i));
    end

    // Test 3: LD, PUSH, POP, PUSH around SP_INIT=0x3FE, one wait cycle.
    clear0();
    mem0[0]    = 16'h6540;  // LDI r5,0x40
    mem0[1]    = 16'h7150;  // LD r1,[r5]
    mem0[2]    = 16'h9100;  // PUSH r1
    mem0[3]    = 16'hA400;  // POP r4
    mem0[4]    = 16'h9500;  // PUSH r5
    mem0[5]    = 16'hF000;  // HALT
    mem0[10'h40] = 16'hABCD;
    wait0 = 1;
    reset0();
    wait_halt0("t3_halt", 300);
    check("t3_txn_count",  32'(q0.size()),  32'd10);
    check("t3_ld_addr",    32'(q0[2].addr), 32'h040);
    check("t3_push_addr",  32'(q0[4].addr), 32'h3FD);
    check("t3_push_we",    32'(q0[4].we),   32'd1);
    check("t3_push_data",  q0[4].wdata,     32'hABCD);
    check("t3_pop_addr",   32'(q0[6].addr), 32'h3FD);
    check("t3_pop_we",     32'(q0[6].we),   32'd0);
    check("t3_push2_addr", 32'(q0[8].addr), 32'h3FD);
    check("t3_push2_data", q0[8].wdata,     32'h0040);
    reg0("t3_r1", 1, 32'hABCD);
    reg0("t3_r4", 4, 32'hABCD);

    // Test 4: reset during a stalled ST.
    clear0();
    mem0[0] = 16'h6107;  // LDI r1,7
    mem0[1] = 16'h6220;  // LDI r2,0x20
    mem0[2] = 16'h8120;  // ST r1,[r2]
    mem0[3] = 16'hF000;  // HALT
    wait0 = 0;
    hold_wr0 = 1'b1;
    reset0();
    begin
      int i = 0;
      while (!(mem_req0 === 1'b1 && mem_we0 === 1'b1) && i < 100) begin
        @(negedge clk); #1; i++;
      end
    end
    check("t4_store_pending", 32'(mem_req0 && mem_we0), 32'd1);
    check("t4_store_addr",    32'(mem_addr0), 32'h020);
    repeat (2) @(negedge clk);
    #2 rst0 = 1'b0;
    #1;
    check("t4_req_dropped",  32'(mem_req0),  32'd0);
    check("t4_we_cleared",   32'(mem_we0),   32'd0);
    check("t4_addr_cleared", 32'(mem_addr0), 32'd0);
    check("t4_mem_untouched", 32'(mem0[10'h20]), 32'd0);
    hold_wr0 = 1'b0;
    q0.delete();
    repeat (2) @(posedge clk);
    #1 rst0 = 1'b1;
    begin
      int i = 0;
      while (q0.size() < 1 && i < 20) begin @(negedge clk); #1; i++; end
    end
    check("t4_first_txn_seen", 32'(q0.size() >= 1), 32'd1);
    check("t4_first_txn_addr", 32'(q0[0].addr), 32'd0);
    check("t4_first_txn_we",   32'(q0[0].we),   32'd0);
    wait_halt0("t4_halt", 200);
    check("t4_store_done", 32'(mem0[10'h20]), 32'h0007);

    // Test 5: SP and PC wrap-around.
    clear0();
    mem0[0]      = 16'hC005;  // JZ 5      (not taken first pass)
    mem0[1]      = 16'hB3F0;  // JMP 0x3F0
    mem0[5]      = 16'hF000;  // HALT
    mem0[10'h3F0] = 16'hA600; // POP r6   (reads 0x3FE)
    mem0[10'h3F1] = 16'hA700; // POP r7   (reads 0x3FF, SP->0)
    mem0[10'h3F2] = 16'h9700; // PUSH r7  (writes 0x3FF)
    mem0[10'h3F3] = 16'hB3FF; // JMP 0x3FF
    mem0[10'h3FE] = 16'h5A5A;
    mem0[10'h3FF] = 16'h2000; // SUB r0,r0 -> Z=1, PC wraps to 0
    wait0 = 0;
    reset0();
    wait_halt0("t5_halt", 300);
    check("t5_txn_count",   32'(q0.size()),   32'd12);
    check("t5_pop1_addr",   32'(q0[3].addr),  32'h3FE);
    check("t5_pop2_addr",   32'(q0[5].addr),  32'h3FF);
    check("t5_push_addr",   32'(q0[7].addr),  32'h3FF);
    check("t5_push_we",     32'(q0[7].we),    32'd1);
    check("t5_push_data",   q0[7].wdata,      32'h2000);
    check("t5_fetch_3ff",   32'(q0[9].addr),  32'h3FF);
    check("t5_fetch_wrap0", 32'(q0[10].addr), 32'h000);
    check("t5_jz_taken",    32'(q0[11].addr), 32'h005);
    reg0("t5_r6", 6, 32'h5A5A);
    reg0("t5_r7", 7, 32'h2000);

    // Test 6: wide instance, ADDI to zero, JZ/JN, OR/AND.
    for (int i = 0; i < 4096; i++) mem1[i] = '0;
    mem1[0]      = 32'h63FF;  // LDI r3,-1
    mem1[1]      = 32'h5301;  // ADDI r3,1
    mem1[2]      = 32'hC800;  // JZ 0x800
    mem1[12'h800] = 32'h6401; // LDI r4,1
    mem1[12'h801] = 32'h2340; // SUB r3,r4
    mem1[12'h802] = 32'hD900; // JN 0x900
    mem1[12'h900] = 32'h650F; // LDI r5,0x0F
    mem1[12'h901] = 32'h663C; // LDI r6,0x3C
    mem1[12'h902] = 32'h4560; // OR r5,r6
    mem1[12'h903] = 32'h6755; // LDI r7,0x55
    mem1[12'h904] = 32'h3570; // AND r5,r7
    mem1[12'h905] = 32'hF000; // HALT
    wait1 = 0;
    rst1 = 1'b0;
    q1.delete();
    repeat (2) @(posedge clk);
    #1 rst1 = 1'b1;
    begin
      int i = 0;
      while (q1.size() < 4 && i < 50) begin @(negedge clk); #1; i++; end
    end
    check("t6_fourth_fetch_seen", 32'(q1.size() >= 4), 32'd1);
    check("t6_jz_target", 32'(q1[3].addr), 32'h800);
    reg1("t6_r3_zero", 3, 32'h0);
    wait_halt1("t6_halt", 300);
    check("t6_txn_count",  32'(q1.size()),  32'd12);
    check("t6_jn_target",  32'(q1[6].addr), 32'h900);
    reg1("t6_r3_neg", 3, 32'hFFFF_FFFF);
    reg1("t6_r4",     4, 32'h1);
    reg1("t6_r5_and", 5, 32'h15);
    reg1("t6_r6",     6, 32'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
